// File: rtl/turbo_iter_ctrl.sv
// Iteration scheduler for a turbo decoder sharing one SISO datapath between natural and interleaved halves.
// Optional early termination on stable SISO2 extrinsic signs is enabled by defining TURBO_EARLY_TERM_EN.
module turbo_iter_ctrl #(
    parameter int BLKLEN_MAX  = 6144,
    parameter int BLKLEN_MIN  = 40,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] blklen,
    input  logic [3:0]  max_iter,
    input  logic        abort,
    input  logic [1:0]  siso_fsm_state,
    input  logic        ext_valid,
    input  logic [15:0] ext_data,
    output logic        siso_valid_blklen,
    output logic [15:0] siso_blklen,
    output logic        half_sel,
    output logic        busy,
    output logic        done,
    output logic [3:0]  iter_out,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_FINISH
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t          state, state_next;
    logic [WD_W-1:0] wdog;
    logic [3:0]      max_eff;
    logic            blk_legal, waiting, timeout, last_iter, early_stop;
    logic            valid_d, busy_d, done_d;

    assign blk_legal = (blklen >= 16'(BLKLEN_MIN)) && (blklen <= 16'(BLKLEN_MAX));
    assign waiting   = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign timeout   = waiting && (wdog == WD_LAST);
    assign last_iter = ({1'b0, iter_out} + 5'd1) == {1'b0, max_eff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            siso_valid_blklen <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= state_next;
            siso_valid_blklen <= valid_d;
            busy              <= busy_d;
            done              <= done_d;
        end
    end

    always_comb begin
        state_next = state;  // NOTE: default assignment first so no branch can infer a latch
        unique case (state)
            S_IDLE:      if (start) state_next = blk_legal ? S_LAUNCH : S_FINISH;
            S_LAUNCH:    state_next = abort ? S_FINISH : S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (abort || timeout)          state_next = S_FINISH;
                else if (siso_fsm_state != 2'd0) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (abort || timeout)          state_next = S_FINISH;
                else if (siso_fsm_state == 2'd0) state_next = S_NEXT;
            end
            S_NEXT: begin
                if (abort)                         state_next = S_FINISH;
                else if (!half_sel)                state_next = S_LAUNCH;
                else if (last_iter || early_stop)  state_next = S_FINISH;
                else                               state_next = S_LAUNCH;
            end
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they describe.
    always_comb begin
        valid_d = (state_next == S_LAUNCH);
        done_d  = (state_next == S_FINISH);
        busy_d  = state_next inside {S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            siso_blklen <= '0;
            max_eff     <= 4'd1;
            half_sel    <= 1'b0;
            iter_out    <= '0;
            err         <= 1'b0;
            wdog        <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                if (blk_legal) begin
                    siso_blklen <= blklen;
                    max_eff     <= (max_iter == 4'd0) ? 4'd1 : max_iter;
                    err         <= 1'b0;
                    iter_out    <= '0;
                    half_sel    <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (timeout && !abort) err <= 1'b1;
            if (state == S_NEXT && !abort && half_sel) iter_out <= iter_out + 4'd1;
            if (state == S_NEXT && state_next == S_LAUNCH) half_sel <= ~half_sel;
            // Watchdog restarts on every state change so each wait phase gets a full budget.
            if (waiting && state_next == state) wdog <= wdog + WD_W'(1);
            else                                wdog <= '0;
        end
    end

`ifdef TURBO_EARLY_TERM_EN
    localparam int MEM_AW = $clog2(BLKLEN_MAX);

    logic [15:0] beat_idx, mism_cnt;
    logic        sign_mem [BLKLEN_MAX];
    logic        beat, in_range, unused_ext;

    assign beat       = (state == S_WAIT_DONE) && ext_valid;
    assign in_range   = beat_idx < 16'(BLKLEN_MAX);
    assign early_stop = half_sel && (iter_out != 4'd0) && (mism_cnt == 16'd0);
    assign unused_ext = ^ext_data[14:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx <= '0;
            mism_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            beat_idx <= '0;
            mism_cnt <= '0;
        end else if (beat) begin
            if (beat_idx != 16'hFFFF) beat_idx <= beat_idx + 16'd1;
            if (half_sel && iter_out != 4'd0 && in_range && mism_cnt != 16'hFFFF &&
                sign_mem[beat_idx[MEM_AW-1:0]] != ext_data[15])
                mism_cnt <= mism_cnt + 16'd1;
        end
    end

    // NOTE: the sign memory has no reset; it is always written in the first SISO2 half before any compare reads it
    always_ff @(posedge clk) begin
        if (beat && half_sel && in_range) sign_mem[beat_idx[MEM_AW-1:0]] <= ext_data[15];
    end
`else
    logic unused_ext;
    assign unused_ext = ^{ext_valid, ext_data};
    assign early_stop = 1'b0;
`endif

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Self-checking bench for turbo_iter_ctrl: reactive SISO model, per-cycle reference model, directed and random requests.
module tb_turbo_iter_ctrl;

    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] blklen = '0;
    logic [3:0]  max_iter = '0;
    logic        abort = 1'b0;
    logic [1:0]  siso_fsm_state = '0;
    logic        ext_valid = 1'b0;
    logic [15:0] ext_data = '0;
    logic        siso_valid_blklen, half_sel, busy, done, err;
    logic [15:0] siso_blklen;
    logic [3:0]  iter_out;

    turbo_iter_ctrl #(.BLKLEN_MAX(6144), .BLKLEN_MIN(40), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .blklen(blklen), .max_iter(max_iter),
        .abort(abort), .siso_fsm_state(siso_fsm_state), .ext_valid(ext_valid),
        .ext_data(ext_data), .siso_valid_blklen(siso_valid_blklen),
        .siso_blklen(siso_blklen), .half_sel(half_sel), .busy(busy), .done(done),
        .iter_out(iter_out), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

`ifdef TURBO_EARLY_TERM_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    // ---------------- reference model: expected outputs after each clock edge ----------------
    bit        m_pulse, m_done, m_busy, m_half, m_err;
    bit [3:0]  m_iter, m_eff;
    bit [15:0] m_blk;
    bit        m_launched, m_seen, m_pend, m_mism;
    int        m_wcnt, m_idx;
    bit        m_sign [6144];

    task automatic m_finish();
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic m_launch();
        m_pulse    = 1'b1;
        m_launched = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit fin, early;
        if (rst) begin
            m_pulse = 0; m_done = 0; m_busy = 0; m_half = 0; m_err = 0;
            m_iter = 0; m_blk = 0; m_launched = 0; m_seen = 0; m_pend = 0;
        end else begin
            fin = m_done;
            m_pulse = 0;
            m_done = 0;
            if (!m_busy) begin
                // The cycle that shows done is not yet idle, so a start there is dropped.
                if (start && !fin) begin
                    if (blklen >= 16'd40 && blklen <= 16'd6144) begin
                        m_busy = 1; m_err = 0; m_iter = 0; m_half = 0; m_blk = blklen;
                        m_eff = (max_iter == 0) ? 4'd1 : max_iter;
                        m_pend = 0;
                        m_launch();
                    end else begin
                        m_err = 1;
                        m_done = 1;
                    end
                end
            end else if (abort) begin
                m_finish();
            end else if (m_launched) begin
                m_launched = 0; m_seen = 0; m_wcnt = 0; m_idx = 0; m_mism = 0;
            end else if (m_pend) begin
                m_pend = 0;
                if (!m_half) begin
                    m_half = 1;
                    m_launch();
                end else begin
                    early = EARLY_EN && m_iter >= 1 && !m_mism;
                    m_iter++;
                    if (m_iter == m_eff || early) m_finish();
                    else begin
                        m_half = 0;
                        m_launch();
                    end
                end
            end else begin
                if (m_seen && ext_valid) begin
                    if (m_half && m_idx < 6144) begin
                        if (m_iter >= 1 && m_sign[m_idx] != ext_data[15]) m_mism = 1;
                        m_sign[m_idx] = ext_data[15];
                    end
                    if (m_idx < 65535) m_idx++;
                end
                if (m_wcnt == TO - 1) begin
                    m_err = 1;
                    m_finish();
                end else if (!m_seen && siso_fsm_state != 2'd0) begin
                    m_seen = 1;
                    m_wcnt = 0;
                end else if (m_seen && siso_fsm_state == 2'd0) begin
                    m_pend = 1;
                end else begin
                    m_wcnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst)
            check("outputs", {siso_valid_blklen, done, busy, half_sel, err, iter_out, siso_blklen},
                  {m_pulse, m_done, m_busy, m_half, m_err, m_iter, m_blk});
    end

    // ---------------- launch monitor ----------------
    int pulses = 0;
    bit half_q[$];
    always @(negedge clk) begin
        if (!rst && siso_valid_blklen) begin
            pulses++;
            half_q.push_back(half_sel);
        end
    end

    // ---------------- reactive SISO model ----------------
    int        up_delay = 1;
    int        run_len = 10;
    bit        stuck = 0;
    bit        same_sign = 0;
    int        sphase = 0;
    int        scnt = 0;
    bit [15:0] sbeat = 0;
    int        t_enter = 0;

    always begin
        @(negedge clk);
        #2;
        if (rst || done) begin
            sphase = 0;
            siso_fsm_state = 2'd0;
            ext_valid = 1'b0;
        end else begin
            case (sphase)
                0: begin
                    siso_fsm_state = 2'd0;
                    ext_valid = 1'b0;
                    if (siso_valid_blklen) begin
                        sphase = 1;
                        scnt = up_delay;
                        sbeat = 0;
                    end
                end
                1: begin
                    if (scnt == 0) begin
                        sphase = 2;
                        scnt = run_len;
                        siso_fsm_state = stuck ? 2'd2 : 2'd1;
                        t_enter = cyc + 1;
                    end else scnt--;
                end
                default: begin
                    if (stuck) begin
                        siso_fsm_state = 2'd2;
                        ext_valid = 1'b0;
                    end else if (scnt == 0) begin
                        sphase = 0;
                        siso_fsm_state = 2'd0;
                        ext_valid = 1'b0;
                    end else begin
                        scnt--;
                        siso_fsm_state = 2'(1 + scnt % 3);
                        ext_valid = 1'($urandom_range(0, 1));
                        ext_data = same_sign ? {sbeat[0] ^ sbeat[2], 15'($urandom)} : 16'($urandom);
                        if (ext_valid) sbeat++;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [15:0] b, input logic [3:0] mi);
        @(negedge clk);
        #1;
        start = 1'b1;
        blklen = b;
        max_iter = mi;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_abort, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (done) at = cyc;
            else begin
                #1;
                abort = rnd_abort && ($urandom_range(0, 149) == 0);
            end
        end
        #1;
        abort = 1'b0;
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int at, p0, d, found;
        bit [3:0] exp_iter;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {siso_valid_blklen, done, busy, half_sel, err, iter_out, siso_blklen}, '0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // blklen 40, two iterations, 100-cycle halves
        run_len = 100; up_delay = 1;
        p0 = pulses;
        half_q.delete();
        do_start(16'd40, 4'd2);
        wait_done(2000, 1'b0, at);
        check("basic_pulses", pulses - p0, 4);
        check("basic_half_seq", {half_q[0], half_q[1], half_q[2], half_q[3]}, 4'b0101);
        check("basic_iter", iter_out, 4'd2);
        check("basic_err", err, 1'b0);
        check("basic_blklen", siso_blklen, 16'd40);
        repeat (3) @(negedge clk);

        // illegal lengths on both sides of the legal range
        run_len = 10;
        p0 = pulses;
        do_start(16'd39, 4'd2);
        check("illegal_low_done", {done, err}, 2'b11);
        do_start(16'd6145, 4'd2);
        check("illegal_high_done", {done, err}, 2'b11);
        repeat (3) @(negedge clk);
        check("illegal_no_launch", pulses - p0, 0);
        do_start(16'd100, 4'd1);
        check("legal_clears_err", {busy, err}, 2'b10);
        wait_done(1000, 1'b0, at);

        // max_iter 0 acts as 1
        p0 = pulses;
        do_start(16'd6144, 4'd0);
        wait_done(1000, 1'b0, at);
        check("maxiter0_pulses", pulses - p0, 2);
        check("maxiter0_iter", iter_out, 4'd1);
        check("maxiter0_blklen", siso_blklen, 16'd6144);
        repeat (3) @(negedge clk);

        // SISO stuck in CALC1: watchdog fires; a start during the wait is ignored
        stuck = 1;
        p0 = pulses;
        do_start(16'd200, 4'd4);
        repeat (300) @(negedge clk);
        do_start(16'd40, 4'd1);
        wait_done(3000, 1'b0, at);
        d = at - t_enter;
        check("timeout_latency_ok", (d >= 998 && d <= 1002), 1'b1);
        check("timeout_err", err, 1'b1);
        check("timeout_iter", iter_out, 4'd0);
        check("timeout_one_launch", pulses - p0, 1);
        stuck = 0;
        repeat (3) @(negedge clk);

        // abort in the second half of iteration 3 of 8
        run_len = 20;
        do_start(16'd500, 4'd8);
        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            @(negedge clk);
            if (busy && iter_out == 4'd2 && half_sel && siso_fsm_state != 2'd0) found = 1;
        end
        check("abort_reached_target", found, 1);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_done", {done, busy, err, iter_out}, {3'b100, 4'd2});
        #1 abort = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid WAIT_DONE
        do_start(16'd300, 4'd3);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (siso_fsm_state != 2'd0) found = 1;
        end
        #1 rst = 1'b1;
        #1 check("midrun_reset_outputs",
                 {siso_valid_blklen, done, busy, half_sel, err, iter_out, siso_blklen}, '0);
        #2 rst = 1'b0;
        found = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        check("midrun_reset_no_done", found, 0);

        // identical SISO2 signs every iteration
        same_sign = 1;
        run_len = 10;
        exp_iter = EARLY_EN ? 4'd2 : 4'd8;
        do_start(16'd64, 4'd8);
        wait_done(3000, 1'b0, at);
        check("early_term_iter", iter_out, exp_iter);
        same_sign = 0;
        repeat (3) @(negedge clk);

        // randomized requests with occasional aborts; the per-cycle compare carries the checks
        for (int t = 0; t < 40; t++) begin
            bit [15:0] b;
            bit        legal;
            legal = ($urandom_range(0, 7) != 0);
            if (legal) b = 16'($urandom_range(40, 6144));
            else       b = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 39))
                                                      : 16'($urandom_range(6145, 7000));
            run_len  = $urandom_range(3, 30);
            up_delay = $urandom_range(0, 3);
            same_sign = ($urandom_range(0, 2) == 0);
            do_start(b, 4'($urandom_range(0, 3)));
            if (legal) wait_done(2000, 1'b1, at);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turbo_iter_ctrl.md
# turbo_iter_ctrl

Iteration scheduler for the turbo decoder's single shared SISO (alpha/beta/extrinsic) datapath. Accepts one decode request, launches the SISO once per half-iteration through its `valid_blklen` start pulse, and alternates natural-order (SISO1) and interleaved (SISO2) halves. Detects half completion from the SISO's 2-bit FSM state. Stops after `max_iter` full iterations, on watchdog timeout, or optionally on early convergence.

## Interface
- `BLKLEN_MAX`, 6144, largest legal block length
- `BLKLEN_MIN`, 40, smallest legal block length
- `TIMEOUT_CYC`, 65535, watchdog limit in cycles per half-iteration
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, request pulse; sampled only in IDLE
- `blklen` in 16, block length; latched on accepted `start`
- `max_iter` in 4, full-iteration limit; latched on accepted `start`; 0 is treated as 1
- `abort` in 1, level; forces FINISH from any busy state
- `siso_fsm_state` in 2, SISO state: 0 IDLE, 1 CALC0, 2 CALC1, 3 SAVE
- `ext_valid` in 1, SISO extrinsic beat strobe
- `ext_data` in 16, SISO extrinsic value, two's complement
- `siso_valid_blklen` out 1, one-cycle SISO launch pulse
- `siso_blklen` out 16, latched block length; held stable while `busy`
- `half_sel` out 1, 0 = SISO1 natural order, 1 = SISO2 interleaved; steers the upstream muxes
- `busy` out 1, high from accepted `start` until `done`
- `done` out 1, one-cycle completion pulse
- `iter_out` out 4, number of completed full iterations
- `err` out 1, sticky; set on illegal `blklen` or timeout; cleared on the next accepted `start`

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, NEXT, FINISH.
- **IDLE**
  - `start`=1 with `blklen` in [BLKLEN_MIN, BLKLEN_MAX]: latch the inputs, clear `err`, `iter_out`=0, `half_sel`=0, go to LAUNCH.
  - `start`=1 with an illegal `blklen`: set `err`, go to FINISH. No launch is issued.
- **LAUNCH**
  - Drive `siso_valid_blklen`=1 for exactly this cycle, clear the watchdog, go to WAIT_BUSY.
- **WAIT_BUSY**
  - Wait for `siso_fsm_state`≠0, then go to WAIT_DONE with the watchdog cleared.
- **WAIT_DONE**
  - Wait for `siso_fsm_state`==0; the half is then complete, go to NEXT.
  - Count `ext_valid` beats in a 16-bit beat index, saturating at 0xFFFF.
- **NEXT**
  - `half_sel`=0: set `half_sel`=1, go to LAUNCH.
  - `half_sel`=1: increment `iter_out`.
    - If `iter_out`+1 == effective `max_iter`, or early termination fires, go to FINISH.
    - Otherwise set `half_sel`=0 and go to LAUNCH.
- **FINISH**
  - Pulse `done` for one cycle, drop `busy`, go to IDLE.
- **Watchdog**
  - Counts cycles in WAIT_BUSY and WAIT_DONE.
  - At TIMEOUT_CYC: set `err`, go to FINISH. `iter_out` keeps the count of completed iterations.
- **`abort`** in LAUNCH/WAIT_*/NEXT: go to FINISH next cycle. `err` is not set.
- **Simultaneous events**
  - `abort` has priority over timeout; timeout has priority over completion.
  - `start` while `busy` is ignored.

## Timing
- Reset values: `siso_valid_blklen`=0, `siso_blklen`=0, `half_sel`=0, `busy`=0, `done`=0, `iter_out`=0, `err`=0. State is IDLE.
- Reset asserted mid-operation returns to IDLE immediately. No `done` is issued.
- Accepted `start` at cycle N:
  - `busy`=1 and state LAUNCH at N+1.
  - `siso_valid_blklen` high during N+1.
- `siso_fsm_state` returning to 0 at cycle M: NEXT at M+1, and either `siso_valid_blklen` at M+2 or `done` at M+2.
- Illegal `blklen`: `err`=1 at N+1, `done` pulse at N+1.
- All outputs are registered.

## Configuration
- `TURBO_EARLY_TERM_EN`
  - **Defined:**
    - Adds a BLKLEN_MAX×1-bit sign memory, indexed by beat index, written on each `ext_valid` during `half_sel`=1.
    - During `half_sel`=1 with `iter_out`≥1, each beat's sign bit is compared with the stored bit; mismatches are counted.
    - A zero mismatch count at the end of that half terminates decoding early at NEXT.
  - **Undefined:** no sign memory; decoding always runs the full effective `max_iter`.

## Test plan
- `blklen`=40, `max_iter`=2, SISO model returns to state 0 after 100 cycles → exactly 4 `siso_valid_blklen` pulses, `half_sel` sequence 0,1,0,1, `done` with `iter_out`=2, `err`=0.
- `blklen`=39, then `blklen`=6145 → each gives `done` one cycle after `start` with `err`=1 and no launch; a following legal `start` clears `err`.
- `max_iter`=0, `blklen`=6144 → treated as 1: two launches, `iter_out`=1.
- SISO model stuck in state 2, TIMEOUT_CYC=1000 → `err`=1 and `done` 1000 cycles (±2) after entering WAIT_DONE; `start` pulsed during the wait is ignored.
- `abort` asserted in the second half of iteration 3 of 8 → `done` next cycle, `iter_out`=2, `err`=0. Separately, `rst` pulsed mid-WAIT_DONE → all outputs 0 with no `done`.
- With `TURBO_EARLY_TERM_EN`, `max_iter`=8, identical `ext_data` signs every SISO2 half → `done` after iteration 2, `iter_out`=2. Without the macro → `iter_out`=8.
